rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single register-file write port between the pipeline write-back stage and the long-latency multiply/divide unit (MDU). Pipeline writes have priority. MDU results that cannot be written immediately are held in a small FIFO and drained into idle write-port cycles. A starvation guard can request a one-cycle write-back stall so a buffered result is not held indefinitely. The block sits between the write-back stage output and the register file write port.

## Interface
- `FIFO_DEPTH`, default 2: MDU result buffer entries; must be a power of 2 and ≥2.
- `MAX_WAIT`, default 4: consecutive blocked cycles allowed before a stall is requested; range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wb_we`  in  1  write-back stage write enable.
- `wb_rd`  in  5  write-back destination register.
- `wb_data`  in  32  write-back data.
- `mdu_valid`  in  1  MDU result valid.
- `mdu_rd`  in  5  MDU destination register.
- `mdu_data`  in  32  MDU result.
- `mdu_ready`  out  1  arbiter can accept an MDU result this cycle.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `rf_src`  out  1  write source: 0 = pipeline, 1 = MDU.
- `stall_req`  out  1  registered request to hold the write-back stage for one cycle.
- `pend_cnt`  out  $clog2(FIFO_DEPTH+1)  number of buffered MDU results.

## Operation
- Effective pipeline write: `wb_we && wb_rd != 0`. A write to x0 never uses the port.
- MDU handshake:
  - A result is accepted when `mdu_valid && mdu_ready`.
  - `mdu_ready = !full`. It is 0 while `reset` is low.
  - An accepted result with `mdu_rd == 0` is consumed and discarded. It is never written or enqueued.
- Port grant, evaluated every cycle:
  1. In state STALL with FIFO non-empty: write the FIFO head, pop it, `rf_src=1`. The pipeline write is ignored this cycle; the pipeline re-presents it because it is stalled.
  2. Else if there is an effective pipeline write: write it, `rf_src=0`. An accepted MDU result is enqueued.
  3. Else if the FIFO is non-empty: write the FIFO head and pop it, `rf_src=1`. An accepted MDU result is enqueued in the same cycle.
  4. Else if an MDU result is accepted: bypass it. Write it directly with `rf_src=1` and do not enqueue it.
  5. Else: `rf_we=0`.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`.
  - Pop and push in the same cycle leave `pend_cnt` unchanged.
  - No push is possible when full.
- Ordering: MDU results are written in acceptance order. The bypass path is used only when the FIFO is empty.
- Starvation FSM, states IDLE and STALL:
  - `wait_cnt` increments on every clock edge at which the FIFO is non-empty and was not popped. It clears on a pop or when the FIFO is empty.
  - IDLE→STALL on the edge at which `wait_cnt` reaches `MAX_WAIT`. `stall_req=1` while in STALL.
  - STALL→IDLE unconditionally after one cycle; `wait_cnt` clears.
- Reset:
  - Asserting `reset` (low) at any time, including mid-drain, empties the FIFO, drops buffered results, clears `wait_cnt`, and forces IDLE.
  - While reset is low: `rf_we`, `rf_waddr`, `rf_wdata`, `rf_src`, `stall_req`, `mdu_ready` and `pend_cnt` are all 0.

## Timing
- Pipeline write and MDU bypass: combinational, zero-cycle latency from inputs to `rf_*`.
- A buffered result is written no earlier than the cycle after it is accepted. Worst case is `MAX_WAIT` blocked cycles plus 1 STALL cycle per entry ahead of it, plus its own wait.
- `stall_req` is a flop output and is high for exactly one cycle per STALL entry.
- `mdu_ready` and `pend_cnt` depend only on registered state; there is no combinational path from `mdu_valid`.

## Configuration
- `RF_ARB_STARVE_GUARD_EN`
  - Defined: the starvation FSM and `wait_cnt` are built as described.
  - Undefined: no FSM or counter is built, `stall_req` is tied to 0, grant rule 1 never applies, and buffered results drain only in cycles without a pipeline write.

## Test plan
- Reset, then MDU result (rd=5, 0xDEAD_BEEF) with `wb_we=0` → same cycle `rf_we=1`, `rf_waddr=5`, `rf_src=1`; `pend_cnt` stays 0.
- `wb_we=1` (rd=3, 0x1111) and MDU result (rd=7, 0x2222) in the same cycle → pipeline written that cycle, `pend_cnt=1`; next idle cycle writes rd=7 with data 0x2222.
- Hold `wb_we=1` continuously and push two MDU results → `mdu_ready=0` when `pend_cnt=2`. With the guard enabled and `MAX_WAIT=4`: `stall_req=1` for one cycle after 4 blocked cycles, head written in that cycle, and the pipeline write resumes on the next cycle.
- MDU result with rd=0 while the FIFO is empty → `mdu_ready=1`, `rf_we=0`, `pend_cnt=0`; `wb_we=1` with `wb_rd=0` → `rf_we=0`.
- Fill the FIFO, drain it with simultaneous push/pop for 8 cycles → no loss, writes in FIFO order, pointers wrap, `pend_cnt` steady.
- Assert `reset` low with `pend_cnt=2` → all outputs 0 immediately (asynchronous); after release `pend_cnt=0`, `mdu_ready=1`, and no stale writes occur.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: write-back/MDU register-file port arbiter; define RF_ARB_STARVE_GUARD_EN to build the starvation stall guard
module rf_write_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wb_we,
    input  logic [4:0]                        wb_rd,
    input  logic [31:0]                       wb_data,
    input  logic                              mdu_valid,
    input  logic [4:0]                        mdu_rd,
    input  logic [31:0]                       mdu_data,
    output logic                              mdu_ready,
    output logic                              rf_we,
    output logic [4:0]                        rf_waddr,
    output logic [31:0]                       rf_wdata,
    output logic                              rf_src,
    output logic                              stall_req,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pend_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_cfg
        $error("rf_write_arbiter: illegal FIFO_DEPTH/MAX_WAIT");
    end
    entry_t          mem [FIFO_DEPTH];
    entry_t          head;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    logic            empty, full, wb_eff, acc_nz, bypass, use_fifo, push, pop, stall_grant;
`ifdef RF_ARB_STARVE_GUARD_EN
    typedef enum logic {IDLE, STALL} state_t;
    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_nxt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end
    always_comb begin
        wait_nxt  = (state == STALL || empty || pop) ? 4'd0 : wait_cnt + 4'd1;
        state_nxt = (state == IDLE && wait_nxt == 4'(MAX_WAIT)) ? STALL : IDLE;
    end
    always_comb begin
        stall_req   = state == STALL;
        stall_grant = stall_req && !empty;
    end
`else
    always_comb begin
        stall_req   = 1'b0;
        stall_grant = 1'b0;
    end
`endif
    always_comb begin
        empty     = cnt == '0;
        full      = cnt == CW'(FIFO_DEPTH);
        head      = mem[rd_ptr];
        mdu_ready = reset && !full;
        wb_eff    = wb_we && wb_rd != 5'd0;
        acc_nz    = mdu_valid && mdu_ready && mdu_rd != 5'd0;
        use_fifo  = stall_grant || (!wb_eff && !empty);
        bypass    = !wb_eff && empty && acc_nz;
        pop       = use_fifo;
        push      = acc_nz && !bypass;
        pend_cnt  = cnt;
        rf_we     = reset && (use_fifo || wb_eff || bypass);
        rf_src    = reset && (use_fifo || bypass);
        rf_waddr  = !reset ? 5'd0  : use_fifo ? head.rd   : wb_eff ? wb_rd   : bypass ? mdu_rd   : 5'd0;
        rf_wdata  = !reset ? 32'd0 : use_fifo ? head.data : wb_eff ? wb_data : bypass ? mdu_data : 32'd0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: mdu_rd, data: mdu_data};
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready, rf_we, rf_src, stall_req;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  pend_cnt;
    int          checks = 0;
    int          failures = 0;
    logic [36:0] sb_q [$];
    logic [36:0] sb_e;
    int          last;

    rf_write_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
        .stall_req(stall_req), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rf_we"}, 32'(rf_we), 0);
        chk({tag, " rf_waddr"}, 32'(rf_waddr), 0);
        chk({tag, " rf_wdata"}, rf_wdata, 0);
        chk({tag, " rf_src"}, 32'(rf_src), 0);
        chk({tag, " stall_req"}, 32'(stall_req), 0);
        chk({tag, " mdu_ready"}, 32'(mdu_ready), 0);
        chk({tag, " pend_cnt"}, 32'(pend_cnt), 0);
    endtask

    task automatic step(input string tag,
                        input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic e_we, input logic e_src, input logic [4:0] e_addr,
                        input logic e_ready, input int e_pend, input logic e_stall);
        wb_we = we; wb_rd = rd; wb_data = d;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
        #2;
        if (mv && e_ready && mrd != 5'd0) sb_q.push_back({mrd, md});
        chk({tag, " rf_we"}, 32'(rf_we), 32'(e_we));
        chk({tag, " mdu_ready"}, 32'(mdu_ready), 32'(e_ready));
        chk({tag, " pend_cnt"}, 32'(pend_cnt), e_pend);
        chk({tag, " stall_req"}, 32'(stall_req), 32'(e_stall));
        if (e_we) begin
            chk({tag, " rf_src"}, 32'(rf_src), 32'(e_src));
            chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(e_addr));
            if (e_src) begin
                chk({tag, " sb_nonempty"}, 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    sb_e = sb_q.pop_front();
                    chk({tag, " sb_addr"}, 32'(rf_waddr), 32'(sb_e[36:32]));
                    chk({tag, " sb_data"}, rf_wdata, sb_e[31:0]);
                end
            end else begin
                chk({tag, " wb_data"}, rf_wdata, d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234; mdu_valid = 1'b1; mdu_rd = 5'd6;
        #3;
        chk_zero("in_reset");
        @(posedge clk); #1;
        chk_zero("in_reset2");
        @(posedge clk); #1;
        reset = 1'b1;
        // bypass with empty FIFO
        step("bypass", 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 1, 1, 5, 1, 0, 0);
        step("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // collision: pipeline wins, MDU buffered
        step("coll", 1, 3, 32'h1111, 1, 7, 32'h2222, 1, 0, 3, 1, 0, 0);
        step("coll_drain", 0, 0, 0, 0, 0, 0, 1, 1, 7, 1, 1, 0);
        step("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // continuous pipeline writes block the FIFO
        step("blk0", 1, 1, 32'hA1, 1, 9, 32'h9000, 1, 0, 1, 1, 0, 0);
        step("blk1", 1, 2, 32'hA2, 1, 10, 32'hA000, 1, 0, 2, 1, 1, 0);
        step("blk2", 1, 3, 32'hA3, 1, 11, 32'hB000, 1, 0, 3, 0, 2, 0);
        step("blk3", 1, 4, 32'hA4, 0, 0, 0, 1, 0, 4, 0, 2, 0);
        step("blk4", 1, 5, 32'hA5, 0, 0, 0, 1, 0, 5, 0, 2, 0);
`ifdef RF_ARB_STARVE_GUARD_EN
        step("stall", 1, 6, 32'h6666, 0, 0, 0, 1, 1, 9, 0, 2, 1);
        step("resume", 1, 6, 32'h6666, 0, 0, 0, 1, 0, 6, 1, 1, 0);
        step("drain_b", 0, 0, 0, 0, 0, 0, 1, 1, 10, 1, 1, 0);
        step("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`else
        step("noguard", 1, 6, 32'h6666, 0, 0, 0, 1, 0, 6, 0, 2, 0);
        step("drain_a", 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 2, 0);
        step("drain_b", 0, 0, 0, 0, 0, 0, 1, 1, 10, 1, 1, 0);
        step("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`endif
        // x0 destinations never use the port
        step("mdu_x0", 0, 0, 0, 1, 0, 32'h5555, 0, 0, 0, 1, 0, 0);
        step("wb_x0", 1, 0, 32'h7777, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // fill, then steady push/pop with pointer wrap
        step("fill0", 1, 1, 32'hB1, 1, 12, 32'hC000_000C, 1, 0, 1, 1, 0, 0);
        step("fill1", 1, 2, 32'hB2, 1, 13, 32'hC000_000D, 1, 0, 2, 1, 1, 0);
        step("full", 0, 0, 0, 1, 14, 32'hC000_000E, 1, 1, 12, 0, 2, 0);
        last = 13;
        for (int i = 1; i <= 8; i++) begin
            step($sformatf("pp%0d", i), 0, 0, 0, 1, 5'(14 + i), 32'hC000_0000 + 32'(14 + i),
                 1, 1, 5'(last), 1, 1, 0);
            last = 14 + i;
        end
        step("pp_drain", 0, 0, 0, 0, 0, 0, 1, 1, 5'(last), 1, 1, 0);
        step("idle3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // asynchronous reset with two entries buffered
        step("rf0", 1, 1, 32'hD1, 1, 20, 32'hE014, 1, 0, 1, 1, 0, 0);
        step("rf1", 1, 2, 32'hD2, 1, 21, 32'hE015, 1, 0, 2, 1, 1, 0);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hD3; mdu_valid = 1'b1; mdu_rd = 5'd22;
        #1;
        chk("pre_reset pend_cnt", 32'(pend_cnt), 2);
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        sb_q.delete();
        @(posedge clk); #1;
        chk_zero("held_reset");
        reset = 1'b1;
        step("post_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("post_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("post_bypass", 0, 0, 0, 1, 25, 32'hBEEF, 1, 1, 25, 1, 0, 0);
        step("post_idle3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("sb_final_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
